// File: rtl/dig_pkg.sv
// dig_pkg: shared encodings for the digger step controller.
// Key, move and default tile codes plus the FSM state type.
package dig_pkg;

  localparam logic [2:0] KEY_UP    = 3'd1;
  localparam logic [2:0] KEY_DOWN  = 3'd2;
  localparam logic [2:0] KEY_LEFT  = 3'd3;
  localparam logic [2:0] KEY_RIGHT = 3'd4;

  localparam logic [2:0] MV_NONE  = 3'd0;
  localparam logic [2:0] MV_UP    = 3'd1;
  localparam logic [2:0] MV_DOWN  = 3'd2;
  localparam logic [2:0] MV_LEFT  = 3'd3;
  localparam logic [2:0] MV_RIGHT = 3'd4;

  localparam int TILE_EMPTY_DEF   = 0;
  localparam int TILE_DIAMOND_DEF = 4;
  localparam int TILE_ROCK_DEF    = 5;
  localparam int TILE_BAG_DEF     = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_QUERY = 2'd1,
    S_COOL  = 2'd2
  } state_t;

endpackage

// File: rtl/dig_step_target.sv
// dig_step_target: key + position -> one-cell target.
// Flags whether the target stays inside the grid.
module dig_step_target
  import dig_pkg::*;
#(
  parameter int ROWS = 10,
  parameter int COLS = 15,
  parameter int XW   = $clog2(ROWS),
  parameter int YW   = $clog2(COLS)
) (
  input  logic [2:0]    i_key,
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  output logic [XW-1:0] o_tx,
  output logic [YW-1:0] o_ty,
  output logic [2:0]    o_move,
  output logic          o_ok
);

  localparam logic [XW-1:0] XMAX = XW'(ROWS - 1);
  localparam logic [YW-1:0] YMAX = YW'(COLS - 1);

  // decode key into a step and check the grid edge first
  always_comb begin
    o_tx   = i_x;
    o_ty   = i_y;
    o_move = MV_NONE;
    o_ok   = 1'b0;
    unique case (1'b1)
      (i_key == KEY_UP): begin
        o_tx   = i_x - XW'(1);
        o_move = MV_UP;
        o_ok   = (i_x != '0);
      end
      (i_key == KEY_DOWN): begin
        o_tx   = i_x + XW'(1);
        o_move = MV_DOWN;
        o_ok   = (i_x < XMAX);
      end
      (i_key == KEY_LEFT): begin
        o_ty   = i_y - YW'(1);
        o_move = MV_LEFT;
        o_ok   = (i_y != '0);
      end
      (i_key == KEY_RIGHT): begin
        o_ty   = i_y + YW'(1);
        o_move = MV_RIGHT;
        o_ok   = (i_y < YMAX);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dig_step_ctrl.sv
// dig_step_ctrl: digger position unit with map query handshake.
// Steps are bounds-checked, queried, then committed or rejected.
module dig_step_ctrl
  import dig_pkg::*;
#(
  parameter int ROWS         = 10,
  parameter int COLS         = 15,
  parameter int X_START      = 6,
  parameter int Y_START      = 7,
  parameter int TILE_W       = 3,
  parameter int TILE_EMPTY   = TILE_EMPTY_DEF,
  parameter int TILE_DIAMOND = TILE_DIAMOND_DEF,
  parameter int TILE_BAG     = TILE_BAG_DEF,
  parameter int TILE_ROCK    = TILE_ROCK_DEF,
  parameter int COOLDOWN     = 4,
  parameter int Q_TIMEOUT    = 15,
  localparam int XW = $clog2(ROWS),
  localparam int YW = $clog2(COLS),
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1,
  localparam int TW = (Q_TIMEOUT > 1) ? $clog2(Q_TIMEOUT) : 1
) (
  input  logic              Clk,
  input  logic              rst_n,
  input  logic              game_over,
  input  logic [2:0]        key,
  output logic              q_req,
  output logic [XW-1:0]     q_x,
  output logic [YW-1:0]     q_y,
  input  logic              q_valid,
  input  logic [TILE_W-1:0] q_tile,
  output logic [XW-1:0]     x,
  output logic [YW-1:0]     y,
  output logic [2:0]        move,
  output logic [1:0]        en_score,
  output logic              clr_en,
  output logic              busy
);

  localparam logic [TW-1:0] TO_LAST = TW'(Q_TIMEOUT - 1);
  localparam logic [CW-1:0] CD_LOAD =
    (COOLDOWN > 0) ? CW'(COOLDOWN - 1) : '0;

  state_t          r_state, w_state;
  logic [XW-1:0]   r_x, w_x, r_qx, w_qx, w_tx;
  logic [YW-1:0]   r_y, w_y, r_qy, w_qy, w_ty;
  logic            r_req, w_req, r_clr, w_clr, w_ok;
  logic [2:0]      r_move, w_move, w_mv;
  logic [1:0]      r_score, w_score;
  logic [TW-1:0]   r_to, w_to;
  logic [CW-1:0]   r_cool, w_cool;

  dig_step_target #(
    .ROWS (ROWS),
    .COLS (COLS),
    .XW   (XW),
    .YW   (YW)
  ) u_target (
    .i_key  (key),
    .i_x    (r_x),
    .i_y    (r_y),
    .o_tx   (w_tx),
    .o_ty   (w_ty),
    .o_move (w_mv),
    .o_ok   (w_ok)
  );

  // state and datapath registers, reset wins
  always_ff @(posedge Clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_x     <= XW'(X_START);
      r_y     <= YW'(Y_START);
      r_qx    <= '0;
      r_qy    <= '0;
      r_req   <= 1'b0;
      r_move  <= MV_NONE;
      r_score <= '0;
      r_clr   <= 1'b0;
      r_to    <= '0;
      r_cool  <= '0;
    end else begin
      r_state <= w_state;
      r_x     <= w_x;
      r_y     <= w_y;
      r_qx    <= w_qx;
      r_qy    <= w_qy;
      r_req   <= w_req;
      r_move  <= w_move;
      r_score <= w_score;
      r_clr   <= w_clr;
      r_to    <= w_to;
      r_cool  <= w_cool;
    end
  end

  // next state: launch, resolve query, then cool down
  always_comb begin
    w_state = r_state;
    w_x     = r_x;
    w_y     = r_y;
    w_qx    = r_qx;
    w_qy    = r_qy;
    w_req   = r_req;
    w_move  = r_move;
    w_score = '0;
    w_clr   = 1'b0;
    w_to    = r_to;
    w_cool  = r_cool;
    unique case (r_state)
      S_IDLE: begin
        w_move = MV_NONE;
        if (!game_over && w_ok) begin
          w_qx    = w_tx;
          w_qy    = w_ty;
          w_req   = 1'b1;
          w_move  = w_mv;
          w_to    = '0;
          w_state = S_QUERY;
        end
      end
      S_QUERY: begin
        if (game_over) begin
          w_req   = 1'b0;
          w_move  = MV_NONE;
          w_state = S_IDLE;
        end else if (q_valid) begin
          w_req   = 1'b0;
          w_move  = MV_NONE;
          w_state = S_IDLE;
          if (q_tile != TILE_W'(TILE_ROCK)) begin
            w_x    = r_qx;
            w_y    = r_qy;
            w_clr  = (q_tile != TILE_W'(TILE_EMPTY));
            w_cool = CD_LOAD;
            if (q_tile == TILE_W'(TILE_DIAMOND)) begin
              w_score = 2'd1;
            end else if (q_tile == TILE_W'(TILE_BAG)) begin
              w_score = 2'd2;
            end
            if (COOLDOWN > 0) begin
              w_state = S_COOL;
            end
          end
        end else if (r_to == TO_LAST) begin
          w_req   = 1'b0;
          w_move  = MV_NONE;
          w_state = S_IDLE;
        end else begin
          w_to = r_to + TW'(1);
        end
      end
      S_COOL: begin
        w_move = MV_NONE;
        if (r_cool == '0) begin
          w_state = S_IDLE;
        end else begin
          w_cool = r_cool - CW'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign q_req    = r_req;
  assign q_x      = r_qx;
  assign q_y      = r_qy;
  assign x        = r_x;
  assign y        = r_y;
  assign move     = r_move;
  assign en_score = game_over ? 2'd0 : r_score;
  assign clr_en   = r_clr;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_dig_step_ctrl.sv
// tb_dig_step_ctrl: directed bench with a cycle model of the
// digger step rules and a per-cycle output compare.
module tb_dig_step_ctrl;

  logic       Clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_over = 1'b0;
  logic [2:0] key = 3'd0;
  logic       q_valid = 1'b0;
  logic [2:0] q_tile = 3'd0;
  logic       q_req, clr_en, busy;
  logic [3:0] q_x, q_y, x, y;
  logic [2:0] move;
  logic [1:0] en_score;

  int vecs = 0;
  int errs = 0;

  // map responder settings
  bit rsp_on = 1'b0;
  int rsp_lat = 1;
  int rsp_tile = 0;
  bit force_qv = 1'b0;
  int rw = 0;

  // behavioural model state: mode 0 idle, 1 waiting, 2 resting
  bit m_on = 1'b0;
  int m_x, m_y, m_qx, m_qy, m_req, m_mv;
  int m_sc, m_clr, m_mode, m_wait, m_left;

  always #5 Clk = ~Clk;

  dig_step_ctrl dut (
    .Clk       (Clk),
    .rst_n     (rst_n),
    .game_over (game_over),
    .key       (key),
    .q_req     (q_req),
    .q_x       (q_x),
    .q_y       (q_y),
    .q_valid   (q_valid),
    .q_tile    (q_tile),
    .x         (x),
    .y         (y),
    .move      (move),
    .en_score  (en_score),
    .clr_en    (clr_en),
    .busy      (busy)
  );

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // model: step rules evaluated at each rising edge
  initial forever begin
    int dx, dy, tx, ty;
    @(posedge Clk);
    if (!rst_n) begin
      m_x = 6; m_y = 7; m_qx = 0; m_qy = 0;
      m_req = 0; m_mv = 0; m_sc = 0; m_clr = 0;
      m_mode = 0; m_wait = 0; m_left = 0;
      m_on = 1'b1;
    end else if (m_on) begin
      m_sc = 0;
      m_clr = 0;
      if (m_mode == 0) begin
        dx = 0; dy = 0;
        case (int'(key))
          1: dx = -1;
          2: dx = 1;
          3: dy = -1;
          4: dy = 1;
          default: ;
        endcase
        tx = m_x + dx;
        ty = m_y + dy;
        if (!game_over && (dx != 0 || dy != 0) &&
            tx >= 0 && tx <= 9 && ty >= 0 && ty <= 14) begin
          m_qx = tx; m_qy = ty;
          m_req = 1; m_mv = int'(key);
          m_wait = 0; m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (game_over) begin
          m_req = 0; m_mv = 0; m_mode = 0;
        end else if (q_valid) begin
          m_req = 0; m_mv = 0; m_mode = 0;
          if (q_tile != 3'd5) begin
            m_x = m_qx; m_y = m_qy;
            m_sc = (q_tile == 3'd4) ? 1 : (q_tile == 3'd6) ? 2 : 0;
            m_clr = (q_tile != 3'd0) ? 1 : 0;
            m_mode = 2; m_left = 4;
          end
        end else begin
          m_wait++;
          if (m_wait == 15) begin
            m_req = 0; m_mv = 0; m_mode = 0;
          end
        end
      end else begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
    end
  end

  // compare DUT against model away from the active edge
  initial forever begin
    @(negedge Clk);
    if (m_on) begin
      chk("x", int'(x), m_x);
      chk("y", int'(y), m_y);
      chk("q_req", int'(q_req), m_req);
      chk("q_x", int'(q_x), m_qx);
      chk("q_y", int'(q_y), m_qy);
      chk("move", int'(move), m_mv);
      chk("en_score", int'(en_score), game_over ? 0 : m_sc);
      chk("clr_en", int'(clr_en), m_clr);
      chk("busy", int'(busy), (m_mode != 0) ? 1 : 0);
    end
  end

  task automatic tick();
    @(negedge Clk);
    if (rsp_on && q_req) begin
      rw++;
      q_valid = (rw == rsp_lat);
      q_tile = 3'(rsp_tile);
    end else begin
      rw = 0;
      q_valid = force_qv;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int cnt, t6, t5;
    // reset state
    ticks(2);
    rst_n = 1'b1;
    tick();
    chk("rst_x", int'(x), 6);
    chk("rst_y", int'(y), 7);
    chk("rst_qreq", int'(q_req), 0);
    chk("rst_move", int'(move), 0);
    chk("rst_score", int'(en_score), 0);
    chk("rst_busy", int'(busy), 0);

    // up onto a diamond, reply after 3 cycles
    rsp_on = 1'b1; rsp_lat = 3; rsp_tile = 4;
    key = 3'd1;
    tick();
    key = 3'd0;
    chk("t2_qreq", int'(q_req), 1);
    chk("t2_qx", int'(q_x), 5);
    chk("t2_qy", int'(q_y), 7);
    chk("t2_move", int'(move), 1);
    ticks(2);
    chk("t2_held_qx", int'(q_x), 5);
    tick();
    chk("t2_x", int'(x), 5);
    chk("t2_y", int'(y), 7);
    chk("t2_score", int'(en_score), 1);
    chk("t2_clr", int'(clr_en), 1);
    chk("t2_busy0", int'(busy), 1);
    tick();
    chk("t2_score_off", int'(en_score), 0);
    chk("t2_clr_off", int'(clr_en), 0);
    ticks(2);
    chk("t2_busy3", int'(busy), 1);
    tick();
    chk("t2_idle", int'(busy), 0);

    // reset from a moved position
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    tick();
    chk("rst2_x", int'(x), 6);
    chk("rst2_y", int'(y), 7);

    // right onto rock: rejected
    rsp_lat = 1; rsp_tile = 5;
    key = 3'd4;
    tick();
    key = 3'd0;
    chk("t4_qreq", int'(q_req), 1);
    tick();
    chk("t4_qdrop", int'(q_req), 0);
    chk("t4_y", int'(y), 7);
    chk("t4_clr", int'(clr_en), 0);
    chk("t4_busy", int'(busy), 0);

    // down with silent map: timeout
    rsp_on = 1'b0;
    key = 3'd2;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      key = 3'd0;
      if (q_req) cnt++;
    end
    chk("t5_req_len", cnt, 15);
    force_qv = 1'b1;
    ticks(2);
    force_qv = 1'b0;
    tick();
    chk("t5_x", int'(x), 6);
    chk("t5_busy", int'(busy), 0);

    // game over in the reply cycle: abort
    rsp_on = 1'b1; rsp_lat = 2; rsp_tile = 4;
    key = 3'd3;
    tick();
    key = 3'd0;
    tick();
    chk("t6_qv", int'(q_valid), 1);
    game_over = 1'b1;
    tick();
    chk("t6_y", int'(y), 7);
    chk("t6_qreq", int'(q_req), 0);
    chk("t6_score", int'(en_score), 0);
    key = 3'd3;
    ticks(2);
    chk("t6_go_block", int'(q_req), 0);
    game_over = 1'b0;
    key = 3'd0;
    tick();

    // held left key with 1-cycle replies onto bags
    rsp_lat = 1; rsp_tile = 6;
    key = 3'd3;
    t6 = -1; t5 = -1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (y == 4'd6 && t6 < 0) t6 = t;
      if (y == 4'd5) begin
        t5 = t;
        break;
      end
    end
    key = 3'd0;
    chk("t6_hold_y", int'(y), 5);
    chk("t6_period", t5 - t6, 6);
    ticks(6);

    // walk to the top-right corner, then push past it
    rsp_tile = 0;
    key = 3'd1;
    ticks(45);
    chk("t3_x0", int'(x), 0);
    key = 3'd4;
    ticks(70);
    chk("t3_y14", int'(y), 14);
    key = 3'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_up_noreq", int'(q_req), 0);
    end
    key = 3'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_rt_noreq", int'(q_req), 0);
    end
    chk("t3_x", int'(x), 0);
    chk("t3_y", int'(y), 14);
    chk("t3_move", int'(move), 0);
    key = 3'd0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
